// File: rtl/frame_cfg_sync_pkg.sv
// Shared types and constants for the frame configuration holder.
// Reset values of the active/shadow configuration and the default
// legal-range limits live here so every file agrees on them.
package frame_cfg_pkg;

    // Default field widths
    localparam int unsigned CFG_M_W_DEF  = 3;
    localparam int unsigned CFG_SS_W_DEF = 4;
    localparam int unsigned CFG_BW_W_DEF = 3;

    // One channel's configuration at the default widths
    typedef struct packed {
        logic [CFG_M_W_DEF-1:0]  m;
        logic [CFG_SS_W_DEF-1:0] ss;
        logic [CFG_BW_W_DEF-1:0] bw;
    } cfg_t;

    // Reset values of active and shadow registers
    localparam int unsigned CFG_M_RST  = 1;
    localparam int unsigned CFG_SS_RST = 1;
    localparam int unsigned CFG_BW_RST = 0;

    // Default largest legal values
    localparam int unsigned CFG_M_MAX_DEF  = 5;
    localparam int unsigned CFG_SS_MAX_DEF = 10;
    localparam int unsigned CFG_BW_MAX_DEF = 4;

endpackage

// File: rtl/frame_cfg_sync_if.sv
// Configuration write bus: valid/ready handshake carrying a channel
// mask and the requested M/SS/BW, plus the out-of-range error pulse.
interface frame_cfg_sync_if #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned M_W  = 3,
    parameter int unsigned SS_W = 4,
    parameter int unsigned BW_W = 3
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [NCH-1:0]  cfg_mask;
    logic [M_W-1:0]  cfg_m;
    logic [SS_W-1:0] cfg_ss;
    logic [BW_W-1:0] cfg_bw;
    logic            cfg_err;

    modport master (
        output cfg_valid, cfg_mask, cfg_m, cfg_ss, cfg_bw,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_mask, cfg_m, cfg_ss, cfg_bw,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/frame_cfg_sync_chan.sv
// One frame path: shadow register filled by writes, active register
// updated from the shadow only on an enabled start-of-frame, pending
// flag and one-cycle applied pulse. A write and a commit in the same
// cycle commit the old shadow and leave the new value pending.
module frame_cfg_chan
    import frame_cfg_pkg::*;
#(
    parameter int unsigned M_W  = CFG_M_W_DEF,
    parameter int unsigned SS_W = CFG_SS_W_DEF,
    parameter int unsigned BW_W = CFG_BW_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en_i,
    input  logic [M_W-1:0]  wr_m_i,
    input  logic [SS_W-1:0] wr_ss_i,
    input  logic [BW_W-1:0] wr_bw_i,
    input  logic            sof_i,
    output logic [M_W-1:0]  act_m_o,
    output logic [SS_W-1:0] act_ss_o,
    output logic [BW_W-1:0] act_bw_o,
    output logic            pending_o,
    output logic            applied_o
);

    localparam logic [M_W-1:0]  M_RST_C  = M_W'(CFG_M_RST);
    localparam logic [SS_W-1:0] SS_RST_C = SS_W'(CFG_SS_RST);
    localparam logic [BW_W-1:0] BW_RST_C = BW_W'(CFG_BW_RST);

    logic [M_W-1:0]  sh_m_q,  sh_m_d,  act_m_q,  act_m_d;
    logic [SS_W-1:0] sh_ss_q, sh_ss_d, act_ss_q, act_ss_d;
    logic [BW_W-1:0] sh_bw_q, sh_bw_d, act_bw_q, act_bw_d;
    logic            pending_q, pending_d, applied_q, applied_d;
    logic            commit_s;

    // Next-state: commit uses the pre-write shadow; a write always re-arms pending
    always_comb begin
        commit_s = sof_i & pending_q;
        if (commit_s) begin
            act_m_d  = sh_m_q;
            act_ss_d = sh_ss_q;
            act_bw_d = sh_bw_q;
        end else begin
            act_m_d  = act_m_q;
            act_ss_d = act_ss_q;
            act_bw_d = act_bw_q;
        end
        if (wr_en_i) begin
            sh_m_d    = wr_m_i;
            sh_ss_d   = wr_ss_i;
            sh_bw_d   = wr_bw_i;
            pending_d = 1'b1;
        end else begin
            sh_m_d    = sh_m_q;
            sh_ss_d   = sh_ss_q;
            sh_bw_d   = sh_bw_q;
            pending_d = pending_q & ~commit_s;
        end
        applied_d = commit_s;
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_m_q    <= M_RST_C;
            sh_ss_q   <= SS_RST_C;
            sh_bw_q   <= BW_RST_C;
            act_m_q   <= M_RST_C;
            act_ss_q  <= SS_RST_C;
            act_bw_q  <= BW_RST_C;
            pending_q <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            sh_m_q    <= sh_m_d;
            sh_ss_q   <= sh_ss_d;
            sh_bw_q   <= sh_bw_d;
            act_m_q   <= act_m_d;
            act_ss_q  <= act_ss_d;
            act_bw_q  <= act_bw_d;
            pending_q <= pending_d;
            applied_q <= applied_d;
        end
    end

    assign act_m_o   = act_m_q;
    assign act_ss_o  = act_ss_q;
    assign act_bw_o  = act_bw_q;
    assign pending_o = pending_q;
    assign applied_o = applied_q;

endmodule

// File: rtl/frame_cfg_sync.sv
// Per-channel modem configuration holder (M, SS, BW) with frame-aligned
// commit and post-reset delayed ready.
// Optional per-channel start-of-frame counters: define FRAME_CFG_FRAME_CNT_EN.
// Range limits are assumed representable in their field widths.
module frame_cfg_sync
    import frame_cfg_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned M_W     = CFG_M_W_DEF,
    parameter int unsigned SS_W    = CFG_SS_W_DEF,
    parameter int unsigned BW_W    = CFG_BW_W_DEF,
    parameter int unsigned M_MAX   = CFG_M_MAX_DEF,
    parameter int unsigned SS_MAX  = CFG_SS_MAX_DEF,
    parameter int unsigned BW_MAX  = CFG_BW_MAX_DEF,
    parameter int unsigned RST_DLY = 100
) (
    input  logic                clk,
    input  logic                rst,
    frame_cfg_sync_if.slave     cfg_if,
    input  logic [NCH-1:0]      sof,
    output logic [NCH*M_W-1:0]  act_m,
    output logic [NCH*SS_W-1:0] act_ss,
    output logic [NCH*BW_W-1:0] act_bw,
    output logic [NCH-1:0]      cfg_pending,
    output logic [NCH-1:0]      cfg_applied,
    output logic                rst_done
`ifdef FRAME_CFG_FRAME_CNT_EN
    ,
    output logic [NCH*16-1:0]   frame_cnt,
    input  logic                frame_cnt_clr
`endif
);

    localparam logic [15:0]     DLY_C    = 16'(RST_DLY);
    localparam logic [M_W-1:0]  M_MAX_C  = M_W'(M_MAX);
    localparam logic [SS_W-1:0] SS_MAX_C = SS_W'(SS_MAX);
    localparam logic [BW_W-1:0] BW_MAX_C = BW_W'(BW_MAX);

    logic [15:0]    dly_cnt_q, dly_cnt_d;
    logic           rst_done_q, rst_done_d;
    logic           err_q, err_d;
    logic           hs_s, legal_s;
    logic [NCH-1:0] wr_en_s, sof_en_s;

    // Handshake, range check, write fan-out and gated start-of-frame
    always_comb begin
        hs_s    = cfg_if.cfg_valid & rst_done_q;
        legal_s = (cfg_if.cfg_m  <= M_MAX_C) &&
                  (cfg_if.cfg_ss <= SS_MAX_C) &&
                  (cfg_if.cfg_bw <= BW_MAX_C);
        if (hs_s && legal_s) begin
            wr_en_s = cfg_if.cfg_mask;
        end else begin
            wr_en_s = {NCH{1'b0}};
        end
        if (rst_done_q) begin
            sof_en_s = sof;
        end else begin
            sof_en_s = {NCH{1'b0}};
        end
        err_d = hs_s & ~legal_s;
    end

    // Delay counter saturates at RST_DLY; ready latches on reaching it
    always_comb begin
        if (dly_cnt_q < DLY_C) begin
            dly_cnt_d = dly_cnt_q + 16'd1;
        end else begin
            dly_cnt_d = dly_cnt_q;
        end
        rst_done_d = rst_done_q | (dly_cnt_q == DLY_C);
    end

    // Delay counter, ready flag and error pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt_q  <= 16'd0;
            rst_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dly_cnt_q  <= dly_cnt_d;
            rst_done_q <= rst_done_d;
            err_q      <= err_d;
        end
    end

    assign cfg_if.cfg_ready = rst_done_q;
    assign cfg_if.cfg_err   = err_q;
    assign rst_done         = rst_done_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        frame_cfg_chan #(
            .M_W  (M_W),
            .SS_W (SS_W),
            .BW_W (BW_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en_s[gi]),
            .wr_m_i    (cfg_if.cfg_m),
            .wr_ss_i   (cfg_if.cfg_ss),
            .wr_bw_i   (cfg_if.cfg_bw),
            .sof_i     (sof_en_s[gi]),
            .act_m_o   (act_m[gi*M_W +: M_W]),
            .act_ss_o  (act_ss[gi*SS_W +: SS_W]),
            .act_bw_o  (act_bw[gi*BW_W +: BW_W]),
            .pending_o (cfg_pending[gi]),
            .applied_o (cfg_applied[gi])
        );
    end

`ifdef FRAME_CFG_FRAME_CNT_EN
    logic [NCH-1:0][15:0] fcnt_q, fcnt_d;

    // Per-channel wrapping frame counters; clear beats increment
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (frame_cnt_clr) begin
                fcnt_d[i] = 16'd0;
            end else if (sof_en_s[i]) begin
                fcnt_d[i] = fcnt_q[i] + 16'd1;
            end else begin
                fcnt_d[i] = fcnt_q[i];
            end
        end
    end

    // Frame counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= {NCH{16'd0}};
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_frame_cfg_sync.sv
// Directed bench for frame_cfg_sync with a cycle-level reference model
// of the configuration rules and a per-cycle compare process.
module tb_frame_cfg_sync;
    import frame_cfg_pkg::*;

    localparam int NCH   = 2;
    localparam int MW    = 3;
    localparam int SSW   = 4;
    localparam int BWW   = 3;
    localparam int MMAX  = 5;
    localparam int SSMAX = 10;
    localparam int BWMAX = 4;
    localparam int DLY   = 100;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH-1:0]      sof = 2'b00;
    logic [NCH*MW-1:0]   act_m;
    logic [NCH*SSW-1:0]  act_ss;
    logic [NCH*BWW-1:0]  act_bw;
    logic [NCH-1:0]      cfg_pending;
    logic [NCH-1:0]      cfg_applied;
    logic                rst_done;
`ifdef FRAME_CFG_FRAME_CNT_EN
    logic [NCH*16-1:0]   frame_cnt;
    logic                frame_cnt_clr = 1'b0;
`endif

    frame_cfg_sync_if #(.NCH(NCH), .M_W(MW), .SS_W(SSW), .BW_W(BWW)) bus ();

    frame_cfg_sync #(
        .NCH(NCH), .M_W(MW), .SS_W(SSW), .BW_W(BWW),
        .M_MAX(MMAX), .SS_MAX(SSMAX), .BW_MAX(BWMAX), .RST_DLY(DLY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_if      (bus.slave),
        .sof         (sof),
        .act_m       (act_m),
        .act_ss      (act_ss),
        .act_bw      (act_bw),
        .cfg_pending (cfg_pending),
        .cfg_applied (cfg_applied),
        .rst_done    (rst_done)
`ifdef FRAME_CFG_FRAME_CNT_EN
        ,
        .frame_cnt     (frame_cnt),
        .frame_cnt_clr (frame_cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int e_m [NCH], e_ss [NCH], e_bw [NCH];
    int s_m [NCH], s_ss [NCH], s_bw [NCH];
    int e_pend [NCH], e_appl [NCH], e_fc [NCH];
    int e_err;
    int since;
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        bit done, hs, legal;
        if (rst) begin
            model_ok = 1'b1;
            since    = 0;
            e_err    = 0;
            for (int c = 0; c < NCH; c++) begin
                e_m[c] = 1; e_ss[c] = 1; e_bw[c] = 0;
                s_m[c] = 1; s_ss[c] = 1; s_bw[c] = 0;
                e_pend[c] = 0; e_appl[c] = 0; e_fc[c] = 0;
            end
        end else begin
            done  = (since > DLY);
            hs    = bus.cfg_valid && done;
            legal = (int'(bus.cfg_m) <= MMAX) && (int'(bus.cfg_ss) <= SSMAX) &&
                    (int'(bus.cfg_bw) <= BWMAX);
            e_err = (hs && !legal) ? 1 : 0;
            for (int c = 0; c < NCH; c++) begin
                e_appl[c] = 0;
                if (sof[c] && done && e_pend[c] == 1) begin
                    e_m[c] = s_m[c]; e_ss[c] = s_ss[c]; e_bw[c] = s_bw[c];
                    e_pend[c] = 0;
                    e_appl[c] = 1;
                end
                if (hs && legal && bus.cfg_mask[c]) begin
                    s_m[c] = int'(bus.cfg_m); s_ss[c] = int'(bus.cfg_ss); s_bw[c] = int'(bus.cfg_bw);
                    e_pend[c] = 1;
                end
`ifdef FRAME_CFG_FRAME_CNT_EN
                if (frame_cnt_clr) e_fc[c] = 0;
                else if (sof[c] && done) e_fc[c] = (e_fc[c] + 1) % 65536;
`endif
            end
            if (since < 1000) since++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            chk("rst_done", int'(rst_done), int'(since > DLY));
            chk("cfg_ready", int'(bus.cfg_ready), int'(since > DLY));
            chk("cfg_err", int'(bus.cfg_err), e_err);
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("act_m[%0d]", c), int'(act_m[c*MW +: MW]), e_m[c]);
                chk($sformatf("act_ss[%0d]", c), int'(act_ss[c*SSW +: SSW]), e_ss[c]);
                chk($sformatf("act_bw[%0d]", c), int'(act_bw[c*BWW +: BWW]), e_bw[c]);
                chk($sformatf("pending[%0d]", c), int'(cfg_pending[c]), e_pend[c]);
                chk($sformatf("applied[%0d]", c), int'(cfg_applied[c]), e_appl[c]);
`ifdef FRAME_CFG_FRAME_CNT_EN
                chk($sformatf("frame_cnt[%0d]", c), int'(frame_cnt[c*16 +: 16]), e_fc[c]);
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive_wr(input logic [1:0] mask, input int m, input int ss, input int bw);
        bus.cfg_valid = 1'b1;
        bus.cfg_mask  = mask;
        bus.cfg_m     = MW'(m);
        bus.cfg_ss    = SSW'(ss);
        bus.cfg_bw    = BWW'(bw);
    endtask

    task automatic wr(input logic [1:0] mask, input int m, input int ss, input int bw);
        drive_wr(mask, m, ss, bw);
        step();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 1; i <= DLY; i++) begin
            if (i == 40) begin
                sof = 2'b11;
                drive_wr(2'b11, 2, 2, 2);
            end else begin
                sof = 2'b00;
                bus.cfg_valid = 1'b0;
            end
            step();
        end
        sof = 2'b00;
        bus.cfg_valid = 1'b0;
        chk({tag, "_rst_done_edge100"}, int'(rst_done), 0);
        step();
        chk({tag, "_rst_done_edge101"}, int'(rst_done), 1);
        chk({tag, "_ready_edge101"}, int'(bus.cfg_ready), 1);
        chk({tag, "_pending"}, int'(cfg_pending), 0);
        chk({tag, "_act_m"}, int'(act_m), 9);
        chk({tag, "_act_ss"}, int'(act_ss), 17);
        chk({tag, "_act_bw"}, int'(act_bw), 0);
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_mask  = 2'b00;
        bus.cfg_m     = 3'd0;
        bus.cfg_ss    = 4'd0;
        bus.cfg_bw    = 3'd0;
        repeat (3) step();
        chk("reset_ready", int'(bus.cfg_ready), 0);
        chk("reset_applied", int'(cfg_applied), 0);
        rst = 1'b0;
        wait_ready("rel");

        // basic write and commit on channel 0
        wr(2'b01, 4, 7, 2);
        chk("wr0_pending", int'(cfg_pending), 1);
        chk("wr0_act_unchanged", int'(act_m[2:0]), 1);
        sof = 2'b01; step(); sof = 2'b00;
        chk("c0_m", int'(act_m[2:0]), 4);
        chk("c0_ss", int'(act_ss[3:0]), 7);
        chk("c0_bw", int'(act_bw[2:0]), 2);
        chk("c0_applied", int'(cfg_applied), 1);
        chk("c0_pending", int'(cfg_pending), 0);
        chk("c1_m_kept", int'(act_m[5:3]), 1);
        chk("c1_ss_kept", int'(act_ss[7:4]), 1);
        chk("c1_bw_kept", int'(act_bw[5:3]), 0);
        step();
        chk("c0_applied_pulse", int'(cfg_applied), 0);

        // out-of-range M
        wr(2'b11, 6, 0, 0);
        chk("err_m_pulse", int'(bus.cfg_err), 1);
        chk("err_m_pending", int'(cfg_pending), 0);
        step();
        chk("err_m_oneshot", int'(bus.cfg_err), 0);
        sof = 2'b11; step(); sof = 2'b00;
        chk("err_m_no_apply", int'(cfg_applied), 0);
        chk("err_m_act_kept", int'(act_m[2:0]), 4);

        // boundaries: SS and BW just above max, all-max legal
        wr(2'b01, 5, 11, 0);
        chk("err_ss", int'(bus.cfg_err), 1);
        wr(2'b01, 0, 0, 5);
        chk("err_bw", int'(bus.cfg_err), 1);
        wr(2'b00, 5, 10, 4);
        chk("mask0_no_err", int'(bus.cfg_err), 0);
        chk("mask0_no_pending", int'(cfg_pending), 0);
        wr(2'b10, 5, 10, 4);
        chk("max_no_err", int'(bus.cfg_err), 0);
        chk("max_pending", int'(cfg_pending), 2);
        sof = 2'b10; step(); sof = 2'b00;
        chk("max_m", int'(act_m[5:3]), 5);
        chk("max_ss", int'(act_ss[7:4]), 10);
        chk("max_bw", int'(act_bw[5:3]), 4);

        // write colliding with sof on channel 1
        wr(2'b10, 2, 1, 0);
        drive_wr(2'b10, 3, 1, 0);
        sof = 2'b10; step(); sof = 2'b00; bus.cfg_valid = 1'b0;
        chk("coll_act_old", int'(act_m[5:3]), 2);
        chk("coll_pending", int'(cfg_pending), 2);
        chk("coll_applied", int'(cfg_applied), 2);
        sof = 2'b10; step(); sof = 2'b00;
        chk("coll_act_new", int'(act_m[5:3]), 3);
        chk("coll_pending_clr", int'(cfg_pending), 0);

        // back-to-back writes: last wins, single commit
        wr(2'b01, 1, 2, 3);
        wr(2'b01, 5, 9, 1);
        sof = 2'b01; step();
        chk("b2b_m", int'(act_m[2:0]), 5);
        chk("b2b_ss", int'(act_ss[3:0]), 9);
        chk("b2b_bw", int'(act_bw[2:0]), 1);
        step(); sof = 2'b00;
        chk("b2b_single_commit", int'(cfg_applied), 0);

        // reset while both channels pending
        wr(2'b11, 3, 3, 3);
        chk("pre_rst_pending", int'(cfg_pending), 3);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_pending", int'(cfg_pending), 0);
        chk("rst_ready_low", int'(rst_done), 0);
        wait_ready("rerel");

`ifdef FRAME_CFG_FRAME_CNT_EN
        frame_cnt_clr = 1'b1; sof = 2'b01; step(); frame_cnt_clr = 1'b0; sof = 2'b00;
        chk("fc_clr_prio", int'(frame_cnt[15:0]), 0);
        sof = 2'b01;
        repeat (65537) step();
        sof = 2'b00;
        chk("fc_wrap", int'(frame_cnt[15:0]), 1);
        chk("fc_ch1", int'(frame_cnt[31:16]), 0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_cfg_sync.md
Name: frame_cfg_sync

Overview:
- Parametrised per-channel modem configuration holder (modulation index M, spreading index SS, bandwidth index BW) for NCH frame paths (default 2: ch0 = Tx, ch1 = Rx).
- Writes land in a per-channel shadow register through a valid/ready handshake with range checking.
- Shadow is committed to the active outputs only on that channel's start-of-frame, so parameters never change mid-frame.
- Also generates the post-reset delayed-ready signal for downstream blocks.

Parameters:
- NCH, 2, number of independent frame paths
- M_W, 3, width of M index
- SS_W, 4, width of SS index
- BW_W, 3, width of BW index
- M_MAX, 5, largest legal M value
- SS_MAX, 10, largest legal SS value
- BW_MAX, 4, largest legal BW value
- RST_DLY, 100, cycles from reset release to rst_done (1..65535)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  write request
- cfg_ready  out  1  write accepted when valid&ready
- cfg_mask  in  NCH  channels targeted by the write
- cfg_m  in  M_W  requested M
- cfg_ss  in  SS_W  requested SS
- cfg_bw  in  BW_W  requested BW
- cfg_err  out  1  one-cycle pulse: accepted write was out of range, discarded
- sof  in  NCH  per-channel start-of-frame strobe
- act_m  out  NCH*M_W  active M, channel i at [i*M_W +: M_W]
- act_ss  out  NCH*SS_W  active SS, same packing
- act_bw  out  NCH*BW_W  active BW, same packing
- cfg_pending  out  NCH  shadow holds an uncommitted update
- cfg_applied  out  NCH  one-cycle pulse: commit happened this cycle
- rst_done  out  1  delayed reset-release flag

Behaviour:
- Reset values:
  - act_m = 1, act_ss = 1, act_bw = 0; shadows equal the same values.
  - cfg_pending = 0, cfg_applied = 0, cfg_err = 0, rst_done = 0.
  - Delay counter = 0.
- Delay counter:
  - Increments each cycle with rst low while count < RST_DLY, then saturates.
  - rst_done is registered high when count == RST_DLY, i.e. first high after the (RST_DLY+1)th edge following rst deassertion.
  - rst_done stays high until rst.
- cfg_ready = rst_done (combinational from the register).
- sof is ignored while rst_done = 0.
- Write on a handshake (cfg_valid & cfg_ready):
  - Legal when cfg_m ≤ M_MAX, cfg_ss ≤ SS_MAX and cfg_bw ≤ BW_MAX.
  - Legal write: for every i with cfg_mask[i] = 1, shadow[i] ← {cfg_m, cfg_ss, cfg_bw} and cfg_pending[i] ← 1 on the next edge.
  - Illegal write: no shadow changes; cfg_err pulses on the next cycle.
  - cfg_mask = 0 with legal values: no effect and no error.
- Commit on channel i (sof[i] & rst_done):
  - If cfg_pending[i] = 1: active[i] ← shadow[i], cfg_pending[i] ← 0, cfg_applied[i] pulses, all on the next edge (latency 1).
  - If cfg_pending[i] = 0: no change and no pulse.
- Simultaneous sof[i] and a legal write to channel i:
  - The commit uses the old shadow.
  - The new value is stored and cfg_pending[i] stays 1 for the next sof.
- Back-to-back writes before a sof: last write wins, only one commit.
- Channels are fully independent; sof on several channels in one cycle commits each.
- rst mid-operation: all state returns to reset values on that edge and the delay count restarts; pending updates are lost.

Optional Feature:
- Macro: FRAME_CFG_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt, NCH*16 bits: per-channel wrapping count of sof strobes accepted while rst_done = 1, counted regardless of pending.
  - Reset value 0; 16'hFFFF wraps to 0.
  - Adds input frame_cnt_clr (1 bit), which zeros all counters on the next edge.
  - Clear has priority over a same-cycle increment.
- When undefined: neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package frame_cfg_pkg holds:
  - struct typedef cfg_t {m, ss, bw}, defaulting to the team's 3/4/3 widths;
  - constants CFG_M_RST = 1, CFG_SS_RST = 1, CFG_BW_RST = 0;
  - the default MAX constants.
- One sub-module, frame_cfg_chan: holds one channel's shadow, active register, pending flag and applied pulse, instantiated NCH times by generate.
- Range check, handshake and delay counter live in the top level.

Test Plan:
- Release rst with RST_DLY = 100 → rst_done and cfg_ready first high after edge 101; act_m = 1, act_ss = 1, act_bw = 0 on all channels; a sof issued before that produces no cfg_applied.
- Write M = 4, SS = 7, BW = 2, mask = 2'b01 → cfg_pending = 01, act unchanged. Then sof[0] → next cycle act_m[0] = 4, act_ss[0] = 7, act_bw[0] = 2, cfg_applied = 01, pending = 00; channel 1 stays 1/1/0.
- Write M = 6 (> M_MAX) → cfg_err pulses one cycle, pending stays 00, a following sof changes nothing.
- Write M = 2 to channel 1, then in a single cycle assert sof[1] together with a write of M = 3 → act_m[1] = 2, pending[1] = 1. Next sof[1] → act_m[1] = 3.
- Assert rst for one cycle while pending = 11 → pending = 00, actives reset to 1/1/0, rst_done low for 101 cycles.
- With FRAME_CFG_FRAME_CNT_EN:
  - 65537 sof[0] strobes → frame_cnt[0] = 1.
  - frame_cnt_clr in the same cycle as a sof → count 0.
